// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial byte receiver.
// Build option: define RX_PARITY_EN to add the even-parity bit and o_parity_err.
package serial_rx_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] i_data);
        return ^i_data;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with a selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; r_meta may go metastable, r_sync is the clean copy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/serial_rx.sv
// Serial byte receiver feeding the byte FIFO directly (o_wr -> w_pin, o_dout -> din).
// Frame: start bit, 8 data bits LSB first, optional even parity bit, one stop bit.
// Build option: define RX_PARITY_EN to add the PARITY state and the o_parity_err port.
// CLKS_PER_BIT must be even and at least 4.
//
// state  | meaning
// IDLE   | waiting for the synchronized line to go low
// START  | half-bit wait, then confirm the start bit is still low
// DATA   | sample 8 data bits at bit centres, LSB first
// PARITY | sample the parity bit at its centre
// STOP   | sample the stop bit, emit o_wr / o_frame_err / o_parity_err
module serial_rx
    import serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_in,
    output logic              o_wr,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_frame_err,
`ifdef RX_PARITY_EN
    output logic              o_parity_err,
`endif
    output logic              o_busy
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic              w_rx_s;
    rx_state_e         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit_idx;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_dout;
    logic              r_wr;
    logic              r_frame_err;
`ifdef RX_PARITY_EN
    logic              r_par_bit;
    logic              r_parity_err;
`endif

    // Idle-high line: reset the synchronizer to 1 so reset never looks like a start bit.
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx_in),
        .o_q   (w_rx_s)
    );

    // Receive FSM with registered strobes; returning to IDLE from STOP at the
    // stop-bit centre re-aligns to the next start edge half a bit early.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_dout       <= '0;
            r_wr         <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_wr        <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[DATA_W-1:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_par_bit <= w_rx_s;
                        r_state   <= STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        if (!w_rx_s) begin
                            r_frame_err <= 1'b1;
`ifdef RX_PARITY_EN
                        end else if (even_parity(r_shift) != r_par_bit) begin
                            r_parity_err <= 1'b1;
`endif
                        end else begin
                            r_wr   <= 1'b1;
                            r_dout <= r_shift;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_wr        = r_wr;
    assign o_dout      = r_dout;
    assign o_frame_err = r_frame_err;
`ifdef RX_PARITY_EN
    assign o_parity_err = r_parity_err;
`endif
    assign o_busy      = (r_state != IDLE);

endmodule
